// File: rtl/pacman_grid_pkg.sv
// Shared constants for the pacman grid: map geometry, tile codes and arbiter FSM encoding.
package pacman_grid_pkg;

  localparam int unsigned GRID_COLS = 21;
  localparam int unsigned GRID_ROWS = 23;
  localparam int unsigned X_W       = 5;
  localparam int unsigned Y_W       = 5;
  localparam int unsigned DATA_W    = 3;

  localparam logic [2:0] TILE_EMPTY  = 3'd0;
  localparam logic [2:0] TILE_WALL   = 3'd1;
  localparam logic [2:0] TILE_PELLET = 3'd2;
  localparam logic [2:0] TILE_POWER  = 3'd3;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } arb_state_e;

  // Index width that stays legal for a single requester.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/grid_rr_picker.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module grid_rr_picker #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner_oh,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               any_req
);

  always_comb begin
    logic found;
    int   idx;
    winner_oh  = '0;
    winner_idx = '0;
    found      = 1'b0;
    idx        = 0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      idx = (int'(ptr) + i) % int'(NUM_REQ);
      if (!found && req[idx]) begin
        found          = 1'b1;
        winner_oh[idx] = 1'b1;
        winner_idx     = IDX_W'(idx);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/grid_access_arbiter.sv
// Round-robin arbiter sharing the single-port grid store between requesters; out-of-map
// accesses are trapped. Define GRID_ARB_DISPLAY_PRIO_EN to give requester 0 absolute priority.
module grid_access_arbiter #(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned X_W       = pacman_grid_pkg::X_W,
  parameter int unsigned Y_W       = pacman_grid_pkg::Y_W,
  parameter int unsigned DATA_W    = pacman_grid_pkg::DATA_W,
  parameter int unsigned GRID_COLS = pacman_grid_pkg::GRID_COLS,
  parameter int unsigned GRID_ROWS = pacman_grid_pkg::GRID_ROWS
) (
  input  logic                      clock_50,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*X_W-1:0]    req_x,
  input  logic [NUM_REQ*Y_W-1:0]    req_y,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic [X_W-1:0]            grid_x,
  output logic [Y_W-1:0]            grid_y,
  output logic [DATA_W-1:0]         grid_data_in,
  output logic                      grid_readwrite,
  input  logic [DATA_W-1:0]         grid_data_out
);
  import pacman_grid_pkg::*;

  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    rr_q, rr_d, pick_idx, win_idx;
  logic [NUM_REQ-1:0]  pick_req, pick_oh, win_oh, grant_oh_q;
  logic                pick_any, win_any, take, in_range, we_q;
  logic [X_W-1:0]      x_q;
  logic [Y_W-1:0]      y_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q, rdata_now;

  logic [X_W-1:0]    x_arr     [NUM_REQ];
  logic [Y_W-1:0]    y_arr     [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign x_arr[g]     = req_x[g*X_W +: X_W];
    assign y_arr[g]     = req_y[g*Y_W +: Y_W];
    assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  grid_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (pick_req),
    .ptr        (rr_q),
    .winner_oh  (pick_oh),
    .winner_idx (pick_idx),
    .any_req    (pick_any)
  );

`ifdef GRID_ARB_DISPLAY_PRIO_EN
  // Display bypasses the rotation; the pointer only cycles over 1..NUM_REQ-1.
  assign pick_req = req & ~NUM_REQ'(1);
  assign win_any  = req[0] | pick_any;
  assign win_oh   = req[0] ? NUM_REQ'(1) : pick_oh;
  assign win_idx  = req[0] ? '0 : pick_idx;
  assign rr_d     = req[0] ? rr_q :
                    (pick_idx == IDX_W'(NUM_REQ - 1)) ? IDX_W'(1) : pick_idx + 1'b1;
`else
  assign pick_req = req;
  assign win_any  = pick_any;
  assign win_oh   = pick_oh;
  assign win_idx  = pick_idx;
  assign rr_d     = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_any) begin
          take    = 1'b1;
          state_d = StAccess;
        end
      end
      StAccess: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_50 or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      rr_q       <= '0;
      grant_oh_q <= '0;
      we_q       <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        rr_q       <= rr_d;
        grant_oh_q <= win_oh;
        we_q       <= req_we[win_idx];
        x_q        <= x_arr[win_idx];
        y_q        <= y_arr[win_idx];
        wdata_q    <= wdata_arr[win_idx];
      end
      if (state_q == StDone) rdata_q <= rdata_now;
    end
  end

  assign in_range = (32'(x_q) < GRID_COLS) && (32'(y_q) < GRID_ROWS);
  assign busy     = (state_q != StIdle);

  // Out-of-map coordinates never leave the arbiter.
  assign grid_x         = (busy && in_range) ? x_q : '0;
  assign grid_y         = (busy && in_range) ? y_q : '0;
  assign grid_data_in   = (busy && in_range) ? wdata_q : '0;
  assign grid_readwrite = (state_q == StAccess) && we_q && in_range;

  assign rdata_now = in_range ? grid_data_out : DATA_W'(TILE_WALL);
  assign ack       = (state_q == StDone) ? grant_oh_q : '0;
  assign rdata     = (state_q == StDone) ? rdata_now : rdata_q;

endmodule
